adc_seq_ctrl: RTL and testbench

- Parametrised multi-channel ADC sequencer; the next-generation ADC power/reset/sample controller.
- Wakes the ADC front end once, then scans every enabled channel in ascending order.
- Each channel runs a free-running or incremental (NSAM-loop) conversion; the scan can repeat continuously with a programmable inter-sweep gap.
- Drives the ADC analog controls (SLP, DAC_STP_EXT, RST_ADC), the channel mux select, and a write strobe tagged with channel and sample index for the downstream capture FIFO.

---
 rtl/adc_seq_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// Multi-channel ADC sequencer: wakes the ADC front end once, then scans every
// enabled channel in ascending order with free-running or incremental
// (NSAM-loop) conversions, optionally repeating sweeps with an idle gap.
module adc_seq_ctrl #(
    parameter int CW  = 32,
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           trigger,
    input  logic           abort,
    input  logic           mode,
    input  logic           cont,
    input  logic [NCH-1:0] ch_en,
    input  logic [CW-1:0]  twake,
    input  logic [CW-1:0]  tsample,
    input  logic [CW-1:0]  nsam,
    input  logic [CW-1:0]  tgap,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic           cfg_err,
    output logic [CHW-1:0] ch_sel,
    output logic           slp,
    output logic           dac_stp_ext,
    output logic           rst_adc,
    output logic           adc_out_wr,
    output logic [CHW-1:0] wr_ch,
    output logic [CW-1:0]  wr_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAKE, S_START, S_SAMPLE, S_NEXT, S_GAP
    } state_t;

    state_t         state_reg, state_next;
    // One bit wider than CW so the incremental sample window can reach tsample+1.
    logic [CW:0]    cnt_reg, cnt_next;
    logic [CW-1:0]  loop_reg, loop_next;
    logic [CHW-1:0] ch_reg, ch_next;
    logic           done_reg, done_next;
    logic           aborted_reg, aborted_next;
    logic           cfg_err_reg, cfg_err_next;

    // Configuration held for the whole run; zero timing/count values become 1.
    logic           mode_reg, cont_reg;
    logic [NCH-1:0] ch_en_reg;
    logic [CW-1:0]  twake_reg, tsample_reg, nsam_reg, tgap_reg;

    logic           capture;
    logic [CW:0]    ts_ext, ts_plus1;
    logic [NCH-1:0] higher_mask;

    assign capture  = (state_reg == S_IDLE) && trigger && (ch_en != '0);
    assign ts_ext   = {1'b0, tsample_reg};
    assign ts_plus1 = ts_ext + (CW+1)'(1);

    // Enabled channels strictly above the current one, used to find the next channel.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_higher
            assign higher_mask[gi] = ch_en_reg[gi] && (CHW'(gi) > ch_reg);
        end
    endgenerate

    function automatic logic [CHW-1:0] lowest_bit(input logic [NCH-1:0] v);
        lowest_bit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = CHW'(i);
        end
    endfunction

    // Latch sanitised configuration on the accepted trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg    <= 1'b0;
            cont_reg    <= 1'b0;
            ch_en_reg   <= '0;
            twake_reg   <= CW'(1);
            tsample_reg <= CW'(1);
            nsam_reg    <= CW'(1);
            tgap_reg    <= CW'(1);
        end else if (capture) begin
            mode_reg    <= mode;
            cont_reg    <= cont;
            ch_en_reg   <= ch_en;
            twake_reg   <= (twake   == '0) ? CW'(1) : twake;
            tsample_reg <= (tsample == '0) ? CW'(1) : tsample;
            nsam_reg    <= (nsam    == '0) ? CW'(1) : nsam;
            tgap_reg    <= (tgap    == '0) ? CW'(1) : tgap;
        end
    end

    // State, counters and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            loop_reg    <= '0;
            ch_reg      <= '0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            loop_reg    <= loop_next;
            ch_reg      <= ch_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        loop_next    = loop_reg;
        ch_next      = ch_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        cfg_err_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (trigger) begin
                    if (ch_en != '0) begin
                        state_next = S_WAKE;
                        cnt_next   = '0;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            S_WAKE: begin
                if (cnt_reg + (CW+1)'(1) == {1'b0, twake_reg}) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    ch_next    = lowest_bit(ch_en_reg);
                    loop_next  = '0;
                end else begin
                    cnt_next = cnt_reg + (CW+1)'(1);
                end
            end
            S_START: begin
                state_next = S_SAMPLE;
                cnt_next   = '0;
            end
            S_SAMPLE: begin
                if (mode_reg) begin
                    if (cnt_reg == ts_plus1) begin
                        cnt_next = '0;
                        if (loop_reg < nsam_reg - CW'(1)) begin
                            loop_next  = loop_reg + CW'(1);
                            state_next = S_START;
                        end else begin
                            state_next = S_NEXT;
                        end
                    end else begin
                        cnt_next = cnt_reg + (CW+1)'(1);
                    end
                end else begin
                    if (cnt_reg + (CW+1)'(1) == ts_ext) begin
                        cnt_next   = '0;
                        state_next = S_NEXT;
                    end else begin
                        cnt_next = cnt_reg + (CW+1)'(1);
                    end
                end
            end
            S_NEXT: begin
                cnt_next = '0;
                if (higher_mask != '0) begin
                    ch_next    = lowest_bit(higher_mask);
                    loop_next  = '0;
                    state_next = S_START;
                end else begin
                    done_next  = 1'b1;
                    state_next = cont_reg ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_reg + (CW+1)'(1) == {1'b0, tgap_reg}) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    ch_next    = lowest_bit(ch_en_reg);
                    loop_next  = '0;
                end else begin
                    cnt_next = cnt_reg + (CW+1)'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort && (state_reg != S_IDLE)) begin
            state_next   = S_IDLE;
            cnt_next     = '0;
            loop_next    = '0;
            done_next    = 1'b0;
            aborted_next = 1'b1;
        end
    end

    // Analog controls and write strobe decoded from registered state only.
    always_comb begin
        busy        = (state_reg != S_IDLE);
        slp         = (state_reg == S_IDLE);
        rst_adc     = (state_reg != S_SAMPLE);
        dac_stp_ext = (state_reg == S_START) || (state_reg == S_SAMPLE) ||
                      (state_reg == S_NEXT);
        adc_out_wr  = (state_reg == S_SAMPLE) && (!mode_reg || (cnt_reg == ts_plus1));
        wr_idx      = mode_reg ? loop_reg : '0;
        ch_sel      = ch_reg;
        wr_ch       = ch_reg;
        done        = done_reg;
        aborted     = aborted_reg;
        cfg_err     = cfg_err_reg;
    end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: directed runs push expected events
// (write strobes, done/aborted/cfg_err pulses) with their exact cycle; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_adc_seq_ctrl;
    localparam int CW  = 4;
    localparam int NCH = 4;
    localparam int CHW = 2;

    localparam int K_WR    = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;
    localparam int K_CFG   = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           trigger = 1'b0;
    logic           abort = 1'b0;
    logic           mode = 1'b0;
    logic           cont = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [CW-1:0]  twake = '0, tsample = '0, nsam = '0, tgap = '0;
    logic           busy, done, aborted, cfg_err;
    logic [CHW-1:0] ch_sel, wr_ch;
    logic           slp, dac_stp_ext, rst_adc, adc_out_wr;
    logic [CW-1:0]  wr_idx;

    adc_seq_ctrl #(.CW(CW), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .mode(mode),
        .cont(cont), .ch_en(ch_en), .twake(twake), .tsample(tsample),
        .nsam(nsam), .tgap(tgap), .busy(busy), .done(done), .aborted(aborted),
        .cfg_err(cfg_err), .ch_sel(ch_sel), .slp(slp), .dac_stp_ext(dac_stp_ext),
        .rst_adc(rst_adc), .adc_out_wr(adc_out_wr), .wr_ch(wr_ch), .wr_idx(wr_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int ch;
        int idx;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic string kname(input int k);
        case (k)
            K_WR:    return "wr";
            K_DONE:  return "done";
            K_ABORT: return "aborted";
            default: return "cfg_err";
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int kind, input int at, input int ch, input int idx);
        exp_t e;
        e.kind = kind; e.at = at; e.ch = ch; e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input int kind, input int ch, input int idx);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: got cyc=%0d ch=%0d idx=%0d, required nothing",
                     kname(kind), cyc, ch, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.at == cyc && e.ch == ch && e.idx == idx) begin
                n_pass++;
                $display("event %s cyc=%0d ch=%0d idx=%0d ok", kname(kind), cyc, ch, idx);
            end else begin
                $display("FAIL event: got %s cyc=%0d ch=%0d idx=%0d, required %s cyc=%0d ch=%0d idx=%0d",
                         kname(kind), cyc, ch, idx, kname(e.kind), e.at, e.ch, e.idx);
            end
        end
    endtask

    // Monitor: compare every presented output event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (adc_out_wr) mon_event(K_WR, int'(wr_ch), int'(wr_idx));
            if (done)       mon_event(K_DONE, 0, 0);
            if (aborted)    mon_event(K_ABORT, 0, 0);
            if (cfg_err)    mon_event(K_CFG, 0, 0);
        end
    end

    // Issue a one-cycle trigger with the given config; c0 is cyc at the drive point,
    // so WAKE (or cfg_err) is visible at cycle c0+1.
    task automatic start(input logic m, input logic c, input logic [NCH-1:0] en,
                         input int tw, input int ts, input int ns, input int tg,
                         output int c0);
        @(posedge clk); #1;
        mode = m; cont = c; ch_en = en;
        twake = CW'(tw); tsample = CW'(ts); nsam = CW'(ns); tgap = CW'(tg);
        trigger = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    // Wait (bounded) for all expected events, then allow a few idle cycles.
    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int nbusy;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_slp_rstadc", {slp, rst_adc}, 2'b11);
        check("rst_dac_wr", {dac_stp_ext, adc_out_wr}, 2'b00);
        check("rst_pulses", {done, aborted, cfg_err}, 3'b000);
        check("rst_ch_sel", ch_sel, 0);
        rst = 1'b0;

        // Mode 0 single shot, channels 0 and 2, twake 3, tsample 4
        start(1'b0, 1'b0, 4'b0101, 3, 4, 1, 1, c0);
        for (int k = 0; k < 4; k++) push(K_WR, c0 + 5 + k, 0, 0);
        for (int k = 0; k < 4; k++) push(K_WR, c0 + 11 + k, 2, 0);
        push(K_DONE, c0 + 16, 0, 0);
        nbusy = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        check("m0_busy_cycles", nbusy, 15);
        drain("m0");

        // Mode 1, channel 1, tsample 2, nsam 3: write on 4th SAMPLE cycle
        start(1'b1, 1'b0, 4'b0010, 2, 2, 3, 1, c0);
        for (int k = 0; k < 3; k++) push(K_WR, c0 + 7 + 5 * k, 1, k);
        push(K_DONE, c0 + 19, 0, 0);
        drain("m1");
        check("m1_idle_busy", busy, 0);

        // Continuous, channel 3 only, tgap 5; abort in first SAMPLE cycle of sweep 3
        start(1'b0, 1'b1, 4'b1000, 1, 2, 1, 5, c0);
        for (int s = 0; s < 2; s++) begin
            push(K_WR, c0 + 3 + 9 * s, 3, 0);
            push(K_WR, c0 + 4 + 9 * s, 3, 0);
            push(K_DONE, c0 + 6 + 9 * s, 0, 0);
        end
        push(K_WR, c0 + 21, 3, 0);
        push(K_ABORT, c0 + 22, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        check("gap_slp_dac", {busy, slp, dac_stp_ext, rst_adc}, 4'b1001);
        check("gap_ch_sel", ch_sel, 3);
        repeat (13) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        drain("cont");

        // Trigger with no channels enabled
        start(1'b0, 1'b0, 4'b0000, 1, 1, 1, 1, c0);
        push(K_CFG, c0 + 1, 0, 0);
        check("cfgerr_busy", busy, 0);
        drain("cfgerr");

        // Abort in IDLE is ignored (monitor flags any aborted pulse)
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Inputs changed mid-run, plus an ignored trigger
        start(1'b0, 1'b0, 4'b0001, 2, 1, 1, 1, c0);
        ch_en = 4'b1111; twake = 4'd9; tsample = 4'd5; mode = 1'b1; trigger = 1'b1;
        push(K_WR, c0 + 4, 0, 0);
        push(K_DONE, c0 + 6, 0, 0);
        @(posedge clk); #1;
        trigger = 1'b0;
        drain("latched");

        // Zero values treated as 1: mode 1 then mode 0
        start(1'b1, 1'b0, 4'b0100, 0, 0, 0, 0, c0);
        push(K_WR, c0 + 5, 2, 0);
        push(K_DONE, c0 + 7, 0, 0);
        drain("zero_m1");
        start(1'b0, 1'b0, 4'b0001, 0, 0, 0, 0, c0);
        push(K_WR, c0 + 3, 0, 0);
        push(K_DONE, c0 + 5, 0, 0);
        drain("zero_m0");

        // tsample all-ones in mode 1: single write at counter 2^CW
        start(1'b1, 1'b0, 4'b0001, 1, 15, 1, 1, c0);
        push(K_WR, c0 + 19, 0, 0);
        push(K_DONE, c0 + 21, 0, 0);
        drain("ts_max");

        // Async reset mid-GAP, then a clean restart
        start(1'b0, 1'b1, 4'b0001, 1, 1, 1, 8, c0);
        push(K_WR, c0 + 3, 0, 0);
        push(K_DONE, c0 + 5, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_ctrl", {slp, rst_adc, dac_stp_ext, adc_out_wr}, 4'b1100);
        check("async_rst_pulses", {done, aborted, cfg_err}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        start(1'b0, 1'b0, 4'b0010, 2, 1, 1, 1, c0);
        push(K_WR, c0 + 4, 1, 0);
        push(K_DONE, c0 + 6, 0, 0);
        drain("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
